// File: rtl/x2050_iar_hist_if.sv
// x2050_iar_hist_if: ROS micro-order inputs and IAR/history outputs of the IAR history unit.
interface x2050_iar_hist_if #(
  parameter int AW    = 24,
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH) + 1;
  logic          i_ros_advance;
  logic [4:0]    i_tr;
  logic [2:0]    i_iv;
  logic [3:0]    i_e;
  logic [1:0]    i_ilc;
  logic [31:0]   i_sdr;
  logic          i_restore;
  logic [AW-1:0] o_nextiar;
  logic [AW-1:0] o_iar;
  logic [AW-1:0] o_hist_top;
  logic [CW-1:0] o_hist_cnt;
  logic          o_overflow;
  logic          o_wrap;
  modport master (
    output i_ros_advance, i_tr, i_iv, i_e, i_ilc, i_sdr, i_restore,
    input  o_nextiar, o_iar, o_hist_top, o_hist_cnt, o_overflow, o_wrap
  );
  modport slave (
    input  i_ros_advance, i_tr, i_iv, i_e, i_ilc, i_sdr, i_restore,
    output o_nextiar, o_iar, o_hist_top, o_hist_cnt, o_overflow, o_wrap
  );
endinterface

// File: rtl/x2050_iar_hist.sv
// x2050_iar_hist: instruction address register with a LIFO history of LOAD/HA origins.
// Define X2050_IAR_WRAP_EN to get a one-cycle o_wrap pulse on increment carry-out.
module x2050_iar_hist #(
  parameter int            AW     = 24,
  parameter int            DEPTH  = 4,
  parameter logic [AW-1:0] HWADDR = 'h84
) (
  input logic              i_clk,
  input logic              i_reset_n,
  x2050_iar_hist_if.slave  s
);
  localparam int CW = $clog2(DEPTH) + 1;
  logic [AW-1:0] iar_q, iar_d, inc4_v, inc2_v, top;
  logic [AW-1:0] hist_q [DEPTH];
  logic [AW-1:0] hist_d [DEPTH];
  logic [CW-1:0] cnt_q, cnt_d;
  logic          ovf_q, ovf_d, pop, load, ha, inc4, inc2, push, full;
  assign load = s.i_tr == 5'd12 || s.i_tr == 5'd21;
  assign ha   = s.i_tr == 5'd8 && s.i_e[2];
  assign inc4 = s.i_iv == 3'd4 || (s.i_iv == 3'd5 && s.i_ilc[1]);
  assign inc2 = s.i_iv == 3'd6 || (s.i_iv == 3'd5 && !s.i_ilc[1]);
  assign pop  = s.i_restore && cnt_q != '0;
  assign push = !pop && (load || ha);
  assign full = cnt_q == CW'(DEPTH);
  assign top  = cnt_q != '0 ? hist_q[0] : '0;
`ifdef X2050_IAR_WRAP_EN
  logic [AW:0] sum4, sum2;
  logic        wrap_q, wrap_d;
  assign sum4   = {1'b0, iar_q} + (AW+1)'(4);
  assign sum2   = {1'b0, iar_q} + (AW+1)'(2);
  assign inc4_v = sum4[AW-1:0];
  assign inc2_v = sum2[AW-1:0];
  assign wrap_d = s.i_ros_advance && !pop && !load && !ha && (inc4 ? sum4[AW] : inc2 && sum2[AW]);
  always_ff @(posedge i_clk)
    wrap_q <= !i_reset_n ? 1'b0 : wrap_d;
  assign s.o_wrap = wrap_q;
`else
  assign inc4_v   = iar_q + AW'(4);
  assign inc2_v   = iar_q + AW'(2);
  assign s.o_wrap = 1'b0;
`endif
  assign s.o_nextiar = pop ? top : load ? s.i_sdr[AW-1:0] : ha ? HWADDR :
                       inc4 ? inc4_v : inc2 ? inc2_v : iar_q;
  assign iar_d = s.i_ros_advance ? s.o_nextiar : iar_q;
  // Newest entry lives at index 0; push shifts toward DEPTH-1, dropping the oldest when full.
  always_comb begin
    hist_d = hist_q;
    cnt_d  = cnt_q;
    ovf_d  = ovf_q;
    if (s.i_ros_advance && pop) begin
      for (int i = 0; i < DEPTH - 1; i++) hist_d[i] = hist_q[i+1];
      hist_d[DEPTH-1] = '0;
      cnt_d = cnt_q - 1'b1;
    end else if (s.i_ros_advance && push) begin
      for (int i = 1; i < DEPTH; i++) hist_d[i] = hist_q[i-1];
      hist_d[0] = iar_q;
      cnt_d = full ? cnt_q : cnt_q + 1'b1;
      ovf_d = ovf_q || full;
    end
  end
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      iar_q <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
      for (int i = 0; i < DEPTH; i++) hist_q[i] <= '0;
    end else begin
      iar_q  <= iar_d;
      cnt_q  <= cnt_d;
      ovf_q  <= ovf_d;
      hist_q <= hist_d;
    end
  end
  assign s.o_iar      = iar_q;
  assign s.o_hist_top = top;
  assign s.o_hist_cnt = cnt_q;
  assign s.o_overflow = ovf_q;
endmodule
